// File: rtl/vfd_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vfd_pwm_pkg
//  Purpose  : Shared types and constants for the VFD supply PWM generator.
//  Revision : 1.0 - initial release
// ============================================================================
package vfd_pwm_pkg;

    // Default width of the period counter and period shadow register.
    localparam int CNT_W_DEF = 16;

    // Width of the duty numerator (duty is expressed over 256).
    localparam int DUTY_W = 8;

    // Width needed for the full period * duty product.
    function automatic int prod_w(input int cnt_w);
        return cnt_w + DUTY_W;
    endfunction

    // Controller states.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } vfd_state_t;

endpackage
`default_nettype wire

// File: rtl/vfd_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vfd_pwm_gen
//  Purpose  : Soft-starting PWM for the VFD filament/grid supply. Period is
//             freq*STEP_US microseconds, steady duty DUTY_NUM/256. Period
//             and duty updates are applied only at period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module vfd_pwm_gen
    import vfd_pwm_pkg::*;
#(
    parameter int STEP_US   = 10,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DUTY_NUM  = 128,
    parameter int RAMP_STEP = 32
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       pluse_us,
    input  logic [7:0] freq,
    output logic       pwm,
    output logic       busy,
    output logic       period_done,
    output logic [7:0] duty_cur
);

    localparam int         c_prod_w    = prod_w(CNT_W);
    localparam logic [7:0] c_duty_num  = 8'(DUTY_NUM);
    localparam logic [7:0] c_ramp_step = 8'(RAMP_STEP);
    // A single ramp step already reaches the target: skip the soft start.
    localparam logic       c_start_run = (RAMP_STEP >= DUTY_NUM);

    vfd_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_per_sh;
    logic [7:0]         r_duty;
    logic               r_pwm;
    logic               r_busy;
    logic               r_done;

    vfd_state_t         w_state_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic [CNT_W-1:0]   w_per_n;
    logic [7:0]         w_duty_n;
    logic               w_bnd;
    logic [CNT_W-1:0]   w_per_new;
    logic [8:0]         w_sum9;
    logic [7:0]         w_ramp;
    logic               w_last;
    logic [c_prod_w-1:0] w_prod;
    logic [CNT_W-1:0]   w_high;
    logic               w_pwm_n;

    // Period length requested by the current freq code.
    assign w_per_new = CNT_W'(freq) * CNT_W'(STEP_US);

    // Next ramp duty, saturated at the steady-state numerator.
    assign w_sum9 = {1'b0, r_duty} + {1'b0, c_ramp_step};
    assign w_ramp = (w_sum9 >= {1'b0, c_duty_num}) ? c_duty_num : w_sum9[7:0];

    // Final tick of the current period.
    assign w_last = (r_cnt == (r_per_sh - CNT_W'(1)));

    // Next-state, counter, period shadow and duty decisions for a tick cycle.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_per_n   = r_per_sh;
        w_duty_n  = r_duty;
        w_bnd     = 1'b0;
        if (pluse_us) begin
            case (r_state)
                OFF: begin
                    if (freq != 8'd0) begin
                        w_per_n = w_per_new;
                        w_cnt_n = '0;
                        if (c_start_run) begin
                            w_duty_n  = c_duty_num;
                            w_state_n = RUN;
                        end else begin
                            w_duty_n  = c_ramp_step;
                            w_state_n = RAMP;
                        end
                    end
                end
                default: begin
                    if (w_last) begin
                        w_bnd   = 1'b1;
                        w_cnt_n = '0;
                        if (freq == 8'd0) begin
                            w_state_n = OFF;
                            w_duty_n  = '0;
                        end else begin
                            w_per_n = w_per_new;
                            if (r_state == RAMP) begin
                                w_duty_n = w_ramp;
                                if (w_ramp == c_duty_num) begin
                                    w_state_n = RUN;
                                end
                            end
                        end
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // High time of the period being entered; evaluated on the post-update
    // period and duty so a new period never starts with stale settings.
    assign w_prod  = c_prod_w'(w_per_n) * c_prod_w'(w_duty_n);
    assign w_high  = CNT_W'(w_prod >> DUTY_W);
    assign w_pwm_n = (w_state_n != OFF) && (w_cnt_n < w_high);

    // State, counter and registered outputs; only tick cycles advance them.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state  <= OFF;
            r_cnt    <= '0;
            r_per_sh <= '0;
            r_duty   <= '0;
            r_pwm    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_bnd;
            if (pluse_us) begin
                r_state  <= w_state_n;
                r_cnt    <= w_cnt_n;
                r_per_sh <= w_per_n;
                r_duty   <= w_duty_n;
                r_pwm    <= w_pwm_n;
                r_busy   <= (w_state_n != OFF);
            end
        end
    end

    assign pwm         = r_pwm;
    assign busy        = r_busy;
    assign period_done = r_done;
    assign duty_cur    = r_duty;

endmodule
`default_nettype wire
